// File: rtl/divu_seq.sv
// divu_seq: sequential restoring divider. One quotient bit is produced per
// clock in CALC. A zero divisor is answered at the load edge.
// Optional feature macro: DIVU_SIGNED_EN adds the Signed input and a
// one-cycle FIXUP state that applies the operand signs to the result.
//
// Ports
//   clk        single clock, rising edge
//   Reset_n    asynchronous active-low reset
//   Run        level request: load from IDLE, hold in CALC/FIXUP/DONE
//   Signed     (DIVU_SIGNED_EN only) signed operation, sampled at load
//   Dividend   numerator, sampled at load edge
//   Divisor    denominator, sampled at load edge
//   Quotient   registered quotient
//   Remainder  registered remainder
//   Ready      result valid (DONE)
//   Busy       operation in progress (CALC/FIXUP)
//   DivZero    last accepted operation had a zero divisor
module divu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             Run,
`ifdef DIVU_SIGNED_EN
    input  logic             Signed,
`endif
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Ready,
    output logic             Busy,
    output logic             DivZero
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned WW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
`ifdef DIVU_SIGNED_EN
        FIXUP = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [WW-1:0]     r_work, w_work_nxt;
    logic [WIDTH-1:0]  r_div, w_div_nxt;
    logic [WIDTH-1:0]  r_q, w_q_nxt;
    logic [WIDTH-1:0]  r_r, w_r_nxt;
    logic              r_dz, w_dz_nxt;
    logic              r_ready, w_ready_nxt;
    logic              r_busy, w_busy_nxt;

    // Operand magnitudes presented to the datapath at load
    logic [WIDTH-1:0]  w_a, w_b;

`ifdef DIVU_SIGNED_EN
    logic              r_neg_q, w_neg_q_nxt;
    logic              r_neg_r, w_neg_r_nxt;
    logic              w_sa, w_sb;
    logic [WIDTH-1:0]  w_q_mag, w_r_mag;

    assign w_sa    = Signed & Dividend[WIDTH-1];
    assign w_sb    = Signed & Divisor[WIDTH-1];
    assign w_a     = w_sa ? (~Dividend + WIDTH'(1)) : Dividend;
    assign w_b     = w_sb ? (~Divisor  + WIDTH'(1)) : Divisor;
    assign w_q_mag = r_work[WIDTH-1:0];
    assign w_r_mag = r_work[WW-1:WIDTH];
`else
    assign w_a = Dividend;
    assign w_b = Divisor;
`endif

    // One restoring step: partial remainder includes the bit shifted out of
    // the upper half, so the compare is WIDTH+1 bits wide. The subtraction
    // result always fits WIDTH bits when the compare succeeds.
    logic [WIDTH:0]    w_part;
    logic [WIDTH-1:0]  w_sub;
    logic              w_ge;
    logic [WW-1:0]     w_iter;

    assign w_part = r_work[WW-1:WIDTH-1];
    assign w_ge   = (w_part >= {1'b0, r_div});
    assign w_sub  = w_part[WIDTH-1:0] - r_div;
    assign w_iter = w_ge ? {w_sub, r_work[WIDTH-2:0], 1'b1}
                         : {r_work[WW-2:0], 1'b0};

    // State and datapath registers
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
`ifdef DIVU_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_work  <= w_work_nxt;
            r_div   <= w_div_nxt;
            r_q     <= w_q_nxt;
            r_r     <= w_r_nxt;
            r_dz    <= w_dz_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
`ifdef DIVU_SIGNED_EN
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
`endif
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_work_nxt  = r_work;
        w_div_nxt   = r_div;
        w_q_nxt     = r_q;
        w_r_nxt     = r_r;
        w_dz_nxt    = r_dz;
`ifdef DIVU_SIGNED_EN
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
`endif
        case (r_state)
            IDLE: begin
                if (Run) begin
                    if (Divisor == '0) begin
                        w_q_nxt     = '1;
                        w_r_nxt     = Dividend;
                        w_dz_nxt    = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_work_nxt  = {WIDTH'(0), w_a};
                        w_div_nxt   = w_b;
                        w_cnt_nxt   = '0;
                        w_dz_nxt    = 1'b0;
`ifdef DIVU_SIGNED_EN
                        w_neg_q_nxt = w_sa ^ w_sb;
                        w_neg_r_nxt = w_sa;
`endif
                        w_state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (!Run) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_work_nxt = w_iter;
                    w_cnt_nxt  = r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        w_cnt_nxt   = '0;
`ifdef DIVU_SIGNED_EN
                        w_state_nxt = FIXUP;
`else
                        w_q_nxt     = w_iter[WIDTH-1:0];
                        w_r_nxt     = w_iter[WW-1:WIDTH];
                        w_state_nxt = DONE;
`endif
                    end
                end
            end
`ifdef DIVU_SIGNED_EN
            FIXUP: begin
                if (!Run) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_q_nxt     = r_neg_q ? (~w_q_mag + WIDTH'(1)) : w_q_mag;
                    w_r_nxt     = r_neg_r ? (~w_r_mag + WIDTH'(1)) : w_r_mag;
                    w_state_nxt = DONE;
                end
            end
`endif
            DONE: begin
                if (!Run) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        w_ready_nxt = (w_state_nxt == DONE);
`ifdef DIVU_SIGNED_EN
        w_busy_nxt  = (w_state_nxt == CALC) || (w_state_nxt == FIXUP);
`else
        w_busy_nxt  = (w_state_nxt == CALC);
`endif
    end

    assign Quotient  = r_q;
    assign Remainder = r_r;
    assign Ready     = r_ready;
    assign Busy      = r_busy;
    assign DivZero   = r_dz;

endmodule

// File: tb/tb_divu_seq.sv
// tb_divu_seq: directed self-checking bench for divu_seq (WIDTH=32).
module tb_divu_seq;

    localparam int unsigned W = 32;
`ifdef DIVU_SIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk;
    logic         Reset_n;
    logic         Run;
`ifdef DIVU_SIGNED_EN
    logic         Signed;
`endif
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Ready;
    logic         Busy;
    logic         DivZero;

    int n_cmp = 0;
    int n_err = 0;

    divu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .Run       (Run),
`ifdef DIVU_SIGNED_EN
        .Signed    (Signed),
`endif
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Ready     (Ready),
        .Busy      (Busy),
        .DivZero   (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start from IDLE with Run low; load, scramble operands, wait for Ready.
    // exp_edges counts edges including the load edge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int exp_edges, input logic [31:0] eq,
                          input logic [31:0] er, input logic edz);
        int n;
        Dividend = a;
        Divisor  = b;
        Run      = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                Dividend = $urandom;
                Divisor  = $urandom;
            end
        end while (!Ready && n <= 100);
        check({tag, "_edges"}, 32'(n), 32'(exp_edges));
        check({tag, "_q"}, Quotient, eq);
        check({tag, "_r"}, Remainder, er);
        check({tag, "_dz"}, {31'b0, DivZero}, {31'b0, edz});
        check({tag, "_busy"}, {31'b0, Busy}, 32'd0);
    endtask

    // Drop Run for one edge and confirm the return to IDLE.
    task automatic go_idle(input string tag);
        Run = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_idle_rdy"}, {31'b0, Ready}, 32'd0);
        check({tag, "_idle_busy"}, {31'b0, Busy}, 32'd0);
    endtask

    initial begin
        Reset_n  = 1'b0;
        Run      = 1'b0;
        Dividend = '0;
        Divisor  = '0;
`ifdef DIVU_SIGNED_EN
        Signed   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", Quotient, 32'd0);
        check("rst_r", Remainder, 32'd0);
        check("rst_rdy", {31'b0, Ready}, 32'd0);
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_dz", {31'b0, DivZero}, 32'd0);
        #3 Reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("d100_7", 32'd100, 32'd7, LAT + 1, 32'd14, 32'd2, 1'b0);
        go_idle("d100_7");

        run_op("d5_0", 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, 1'b1);
        go_idle("d5_0");

        run_op("dmax_1", 32'hFFFF_FFFF, 32'd1, LAT + 1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        go_idle("dmax_1");

        run_op("d1_max", 32'd1, 32'hFFFF_FFFF, LAT + 1, 32'd0, 32'd1, 1'b0);
        go_idle("d1_max");

        run_op("d12345678", 32'd12345678, 32'd1000, LAT + 1, 32'd12345, 32'd678, 1'b0);

        // Run held through DONE: no reload even with new operands present
        Dividend = 32'd999;
        Divisor  = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_rdy", {31'b0, Ready}, 32'd1);
            check("hold_q", Quotient, 32'd12345);
        end
        go_idle("hold");
        run_op("d1000_10", 32'd1000, 32'd10, LAT + 1, 32'd100, 32'd0, 1'b0);
        go_idle("d1000_10");

        // Abort at iteration 10: previous result must survive
        Dividend = 32'd77;
        Divisor  = 32'd5;
        Run      = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy_load", {31'b0, Busy}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_it10", {31'b0, Busy}, 32'd1);
        Run = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", {31'b0, Busy}, 32'd0);
        check("abort_rdy", {31'b0, Ready}, 32'd0);
        check("abort_q", Quotient, 32'd100);
        check("abort_r", Remainder, 32'd0);
        check("abort_dz", {31'b0, DivZero}, 32'd0);

        // Asynchronous reset mid-CALC, asserted between edges
        Dividend = 32'd200;
        Divisor  = 32'd3;
        Run      = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3 Reset_n = 1'b0;
        #1;
        check("amid_q", Quotient, 32'd0);
        check("amid_r", Remainder, 32'd0);
        check("amid_busy", {31'b0, Busy}, 32'd0);
        check("amid_rdy", {31'b0, Ready}, 32'd0);
        check("amid_dz", {31'b0, DivZero}, 32'd0);
        Run = 1'b0;
        #2 Reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("d200_3", 32'd200, 32'd3, LAT + 1, 32'd66, 32'd2, 1'b0);
        go_idle("d200_3");

`ifdef DIVU_SIGNED_EN
        Signed = 1'b1;
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, LAT + 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        go_idle("s_m7_2");
        Signed = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
